// File: rtl/binary_to_gray_unit_pkg.sv
// Shared Gray-code helpers. Functions work on a wide vector so any WIDTH up to
// MAX_W can use them via zero-extension and truncation at the call site.
package binary_to_gray_unit_pkg;

  localparam int unsigned MAX_W = 64;

  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits contribute nothing.
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = int'(MAX_W) - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/binary_to_gray_unit_gray_decode.sv
// Combinational Gray-to-binary decoder (prefix XOR from MSB).
module binary_to_gray_unit_gray_decode
  import binary_to_gray_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_out
);

  always_comb begin
    binary_out = WIDTH'(gray2bin(MAX_W'(gray_in)));
  end

endmodule

// File: rtl/binary_to_gray_unit.sv
// Binary-to-Gray converter: combinational encode, registered encode with valid,
// and a separate combinational Gray decode port.
module binary_to_gray_unit
  import binary_to_gray_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  input  logic             in_valid,
  output logic [WIDTH-1:0] gray_q,
  output logic             out_valid,
  input  logic [WIDTH-1:0] gray_in,
  output logic [WIDTH-1:0] binary_out
);

  logic [WIDTH-1:0] gray_reg_d;
  logic [WIDTH-1:0] gray_reg_q;
  logic             out_valid_d;
  logic             out_valid_q;

  always_comb begin
    gray = WIDTH'(bin2gray(MAX_W'(binary)));
  end

  // Capture on in_valid; otherwise hold the code and drop valid.
  always_comb begin
    gray_reg_d  = gray_reg_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      gray_reg_d  = gray;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_reg_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      gray_reg_q  <= gray_reg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gray_q    = gray_reg_q;
  assign out_valid = out_valid_q;

  binary_to_gray_unit_gray_decode #(.WIDTH(WIDTH)) u_gray_decode (
    .gray_in    (gray_in),
    .binary_out (binary_out)
  );

endmodule

// File: tb/tb_binary_to_gray_unit.sv
// Directed self-checking bench for binary_to_gray_unit (WIDTH=4).
module tb_binary_to_gray_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] binary;
  logic [3:0] gray;
  logic       in_valid;
  logic [3:0] gray_q;
  logic       out_valid;
  logic [3:0] gray_in;
  logic [3:0] binary_out;

  int vectors;
  int fails;

  binary_to_gray_unit #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .binary     (binary),
    .gray       (gray),
    .in_valid   (in_valid),
    .gray_q     (gray_q),
    .out_valid  (out_valid),
    .gray_in    (gray_in),
    .binary_out (binary_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] sweep_bin [12];
  logic [3:0] sweep_gry [12];
  logic [3:0] g0;
  logic [3:0] g1;

  initial begin
    vectors = 0;
    fails   = 0;
    sweep_bin = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                  4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110};
    sweep_gry = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0100,
                  4'b0111, 4'b0110, 4'b1010, 4'b1011, 4'b1000, 4'b1001};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    binary   = '0;
    gray_in  = '0;
    #12;
    check("reset_gray_q", 32'(gray_q), 32'h0);
    check("reset_out_valid", 32'(out_valid), 32'h0);

    // Combinational sweep
    for (int i = 0; i < 12; i++) begin
      binary = sweep_bin[i];
      #5;
      check($sformatf("sweep_gray[%0d]", i), 32'(gray), 32'(sweep_gry[i]));
    end

    // Round trip over all values
    for (int n = 0; n < 16; n++) begin
      binary = 4'(n);
      #1;
      gray_in = gray;
      #1;
      check($sformatf("round_trip[%0d]", n), 32'(binary_out), 32'(n));
    end
    gray_in = 4'b1000;
    #1;
    check("decode_1000", 32'(binary_out), 32'b1111);
    gray_in = 4'b1010;
    #1;
    check("decode_1010", 32'(binary_out), 32'b1100);

    // Adjacent codes differ in one bit, including wrap
    for (int n = 0; n < 16; n++) begin
      binary = 4'(n);
      #1;
      g0 = gray;
      binary = 4'((n + 1) % 16);
      #1;
      g1 = gray;
      check($sformatf("hamming[%0d]", n), 32'($countones(g0 ^ g1)), 32'd1);
    end

    // Registered path
    @(negedge clk);
    rst_n    = 1'b1;
    binary   = 4'b0110;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("reg_gray_q", 32'(gray_q), 32'b0101);
    check("reg_out_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("hold_gray_q", 32'(gray_q), 32'b0101);
    check("hold_out_valid", 32'(out_valid), 32'h0);

    // Async reset between edges
    binary   = 4'b1110;
    in_valid = 1'b1;
    @(posedge clk); #1;
    check("pre_rst_gray_q", 32'(gray_q), 32'b1001);
    check("pre_rst_out_valid", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_gray_q", 32'(gray_q), 32'h0);
    check("async_rst_out_valid", 32'(out_valid), 32'h0);
    in_valid = 1'b0;

    // Back-to-back captures
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    binary   = 4'b1100;
    @(posedge clk); #1;
    check("b2b0_gray_q", 32'(gray_q), 32'b1010);
    check("b2b0_out_valid", 32'(out_valid), 32'h1);
    binary = 4'b1101;
    @(posedge clk); #1;
    check("b2b1_gray_q", 32'(gray_q), 32'b1011);
    check("b2b1_out_valid", 32'(out_valid), 32'h1);
    binary = 4'b1111;
    @(posedge clk); #1;
    check("b2b2_gray_q", 32'(gray_q), 32'b1000);
    check("b2b2_out_valid", 32'(out_valid), 32'h1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_end_out_valid", 32'(out_valid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
